// File: rtl/bundle_acc_if.sv
// bundle_acc_if: control, hypervector and result signals between a core and the bundling accumulator
interface bundle_acc_if #(parameter int DIM = 1023);
  logic run;
  logic store;
  logic last;
  logic [DIM:0] core_result;
  logic [DIM:0] sign_bit;
  logic sign_valid;
  logic [15:0] vec_cnt;
  logic sat;
  modport master(output run, store, last, core_result, input sign_bit, sign_valid, vec_cnt, sat);
  modport slave(input run, store, last, core_result, output sign_bit, sign_valid, vec_cnt, sat);
endinterface

// File: rtl/bundle_acc.sv
// bundle_acc: per-bit saturating vote counters bundling hypervectors into a registered majority vector
module bundle_acc #(
  parameter int DIM = 1023,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rstn,
  bundle_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, FINAL, DONE} state_t;
  localparam logic [CNT_W-1:0] MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_d;
  logic [1:0] rs;
  logic ok, clr, idle_like, take, fin;
  logic [DIM:0] clip, pos;
  // reset asserts immediately but releases two edges later, so the first live edge is clean
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rs <= '0;
    else rs <= {rs[0], 1'b1};
  assign ok = rs[1];
  assign clr = !ok || !bus.run;
  assign idle_like = state == IDLE || state == DONE;
  assign take = !clr && bus.store && state != FINAL;
  assign fin = !clr && state == FINAL;
  always_comb
    state_d = clr ? IDLE
            : state == FINAL ? DONE
            : state == ACC ? (bus.last ? FINAL : ACC)
            : bus.store ? ACC : state;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_d;
  for (genvar i = 0; i <= DIM; i++) begin : g_bit
    logic [CNT_W-1:0] c, b;
    // a store that opens a bundle starts from a cleared counter
    assign b = idle_like ? '0 : c;
    assign clip[i] = bus.core_result[i] ? b == MAX : b == MIN;
    assign pos[i] = !c[CNT_W-1] && c != '0;
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) c <= '0;
      else if (clr) c <= '0;
      else if (take) c <= clip[i] ? b : bus.core_result[i] ? b + ONE : b - ONE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bus.sign_bit <= '0;
      bus.sign_valid <= 1'b0;
      bus.vec_cnt <= '0;
      bus.sat <= 1'b0;
    end else begin
      bus.sign_valid <= fin;
      if (fin) bus.sign_bit <= pos;
      bus.vec_cnt <= clr ? 16'd0
                   : !take ? bus.vec_cnt
                   : idle_like ? 16'd1
                   : bus.vec_cnt == 16'hFFFF ? bus.vec_cnt : bus.vec_cnt + 16'd1;
      bus.sat <= clr ? 1'b0 : take ? !idle_like && (bus.sat || |clip) : bus.sat;
    end
endmodule

// File: tb/tb_bundle_acc.sv
// tb_bundle_acc: directed scoreboard bench for a DIM=7 accumulator plus a DIM=1023 majority-model run
module tb_bundle_acc;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  bundle_acc_if #(.DIM(7)) ba();
  bundle_acc_if #(.DIM(1023)) bb();
  bundle_acc #(.DIM(7), .CNT_W(4)) dut_a (.clk(clk), .rstn(rstn), .bus(ba));
  bundle_acc dut_b (.clk(clk), .rstn(rstn), .bus(bb));
  typedef struct packed {logic [7:0] s; logic [15:0] v; logic sat;} exp_t;
  exp_t qa[$];
  logic [1023:0] qb[$];
  int qbv[$];
  int total = 0, bad = 0;
  exp_t ea;
  logic [1023:0] eb;
  int ev;
  int acc[1024];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc_a(logic st, logic [7:0] d, logic l);
    ba.store = st; ba.core_result = d; ba.last = l;
    @(posedge clk); #1;
    ba.store = 1'b0; ba.last = 1'b0;
  endtask

  task automatic cyc_b(logic st, logic [1023:0] d, logic l);
    bb.store = st; bb.core_result = d; bb.last = l;
    @(posedge clk); #1;
    bb.store = 1'b0; bb.last = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (ba.sign_valid === 1'b1) begin
    total++;
    if (qa.size() == 0) begin
      bad++;
      $display("FAIL pulse_a unexpected: sign_bit=%h vec_cnt=%0d", ba.sign_bit, ba.vec_cnt);
    end else begin
      ea = qa.pop_front();
      if ({ba.sign_bit, ba.vec_cnt, ba.sat} !== ea) begin
        bad++;
        $display("FAIL result_a: got sign=%h vec=%0d sat=%b want sign=%h vec=%0d sat=%b",
                 ba.sign_bit, ba.vec_cnt, ba.sat, ea.s, ea.v, ea.sat);
      end
    end
  end

  always @(negedge clk) if (bb.sign_valid === 1'b1) begin
    total++;
    if (qb.size() == 0) begin
      bad++;
      $display("FAIL pulse_b unexpected: vec_cnt=%0d", bb.vec_cnt);
    end else begin
      eb = qb.pop_front();
      ev = qbv.pop_front();
      if (bb.sign_bit !== eb || bb.vec_cnt !== 16'(ev)) begin
        bad++;
        $display("FAIL result_b: %0d sign bits differ, got vec=%0d want vec=%0d",
                 $countones(bb.sign_bit ^ eb), bb.vec_cnt, ev);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    ba.run = 0; ba.store = 0; ba.last = 0; ba.core_result = '0;
    bb.run = 0; bb.store = 0; bb.last = 0; bb.core_result = '0;
    #1 rstn = 0;
    #20;
    chk("rst_sign", ba.sign_bit, 0);
    chk("rst_valid", ba.sign_valid, 0);
    chk("rst_vec", ba.vec_cnt, 0);
    chk("rst_sat", ba.sat, 0);
    #2 rstn = 1;
    ba.run = 1; bb.run = 1;
    idle(4);
    // majority of three vectors and the exact pulse timing
    qa.push_back({8'hE8, 16'd3, 1'b0});
    cyc_a(1, 8'hF0, 0);
    chk("vec_first", ba.vec_cnt, 1);
    cyc_a(1, 8'hCC, 0);
    cyc_a(1, 8'hAA, 0);
    chk("vec_three", ba.vec_cnt, 3);
    cyc_a(0, 8'h00, 1);
    @(negedge clk); chk("valid_edge_n", ba.sign_valid, 0);
    @(negedge clk); chk("valid_edge_n1", ba.sign_valid, 1);
    chk("sign_majority", ba.sign_bit, 8'hE8);
    @(negedge clk); chk("valid_edge_n2", ba.sign_valid, 0);
    idle(1);
    // tie gives 0, store+last merges the final vector
    qa.push_back({8'h0F, 16'd2, 1'b0});
    cyc_a(1, 8'hFF, 0);
    cyc_a(1, 8'h0F, 1);
    chk("vec_merge", ba.vec_cnt, 2);
    idle(3);
    chk("sign_merge", ba.sign_bit, 8'h0F);
    // abort: run low (with a store present) mid-bundle, then a stray last
    cyc_a(1, 8'h33, 0);
    cyc_a(1, 8'h55, 0);
    chk("vec_before_abort", ba.vec_cnt, 2);
    ba.run = 0;
    cyc_a(1, 8'hFF, 0);
    ba.run = 1;
    chk("abort_vec", ba.vec_cnt, 0);
    chk("abort_sat", ba.sat, 0);
    cyc_a(0, 8'h00, 1);
    idle(3);
    chk("abort_sign_kept", ba.sign_bit, 8'h0F);
    chk("idle_last_vec", ba.vec_cnt, 0);
    // saturation: bit0 reaches +7 after 7 stores and clips on the 8th
    qa.push_back({8'h01, 16'd9, 1'b1});
    for (int k = 1; k <= 9; k++) begin
      cyc_a(1, 8'h01, 0);
      if (k == 1) chk("idle_store_vec", ba.vec_cnt, 1);
      if (k == 7) chk("sat_not_yet", ba.sat, 0);
    end
    chk("sat_set", ba.sat, 1);
    chk("vec_nine", ba.vec_cnt, 9);
    cyc_a(0, 8'h00, 1);
    idle(3);
    // held at +7 then seven downs gives 0; a wrapping counter would not
    qa.push_back({8'h00, 16'd16, 1'b1});
    repeat (9) cyc_a(1, 8'h01, 0);
    repeat (7) cyc_a(1, 8'h00, 0);
    cyc_a(0, 8'h00, 1);
    idle(3);
    cyc_a(1, 8'hF0, 0);
    chk("done_store_sat", ba.sat, 0);
    chk("done_store_vec", ba.vec_cnt, 1);
    // store during FINAL is dropped, last in DONE is ignored
    qa.push_back({8'hF0, 16'd1, 1'b0});
    cyc_a(0, 8'h00, 1);
    cyc_a(1, 8'hFF, 0);
    chk("final_store_vec", ba.vec_cnt, 1);
    idle(2);
    cyc_a(0, 8'h00, 1);
    idle(3);
    chk("done_last_vec", ba.vec_cnt, 1);
    chk("done_last_sign", ba.sign_bit, 8'hF0);
    // asynchronous reset mid-bundle
    cyc_a(1, 8'hFF, 0);
    cyc_a(1, 8'hFF, 0);
    #2 rstn = 0;
    #1;
    chk("async_sign", ba.sign_bit, 0);
    chk("async_valid", ba.sign_valid, 0);
    chk("async_vec", ba.vec_cnt, 0);
    chk("async_sat", ba.sat, 0);
    cyc_a(1, 8'hFF, 0);
    #3 rstn = 1;
    idle(3);
    chk("rst_store_dropped", ba.vec_cnt, 0);
    qa.push_back({8'h0F, 16'd1, 1'b0});
    cyc_a(1, 8'h0F, 0);
    cyc_a(0, 8'h00, 1);
    idle(3);
    // wide build against a reference majority
    for (int n = 0; n < 4; n++) begin
      logic [1023:0] v, e;
      int nv;
      nv = 2 + n;
      for (int i = 0; i < 1024; i++) acc[i] = 0;
      for (int k = 0; k < nv; k++) begin
        for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
        for (int i = 0; i < 1024; i++) acc[i] += v[i] ? 1 : -1;
        cyc_b(1, v, (k == nv - 1) && n[0]);
      end
      if (!n[0]) cyc_b(0, '0, 1);
      for (int i = 0; i < 1024; i++) e[i] = acc[i] > 0;
      qb.push_back(e);
      qbv.push_back(nv);
      idle(3);
    end
    idle(5);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
